// File: rtl/approx_stats_pkg.sv
// Shared types and default widths for the approximate-multiplier error-statistics engine.
package approx_stats_pkg;

    // Default configuration: 8-bit multiplier operands, 16-bit sample window,
    // relative error carried as Q(.16).
    localparam int PKG_W     = 8;
    localparam int PKG_CNT_W = 16;
    localparam int PKG_FRAC  = 16;

    // Derived widths for the default configuration.
    localparam int PROD_W    = 2 * PKG_W;
    localparam int DIV_W     = 2 * PKG_W + PKG_FRAC;
    localparam int DIV_CYC   = 2 * PKG_W + PKG_FRAC;
    localparam int SUM_ABS_W = PROD_W + PKG_CNT_W;
    localparam int SUM_SGN_W = PROD_W + PKG_CNT_W + 1;
    localparam int SUM_RE_W  = PROD_W + PKG_FRAC + PKG_CNT_W;

    // Engine control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle, DVD_W cycles per divide.
// The final quotient is presented combinationally during the last busy cycle
// (q_valid high) so the caller can consume it without an extra wait state.
module seq_restoring_div #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             q_valid,
    output logic [DVD_W-1:0] quotient
);

    localparam int CW = $clog2(DVD_W + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(DVD_W);

    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DVS_W:0]   trial_s;
    logic             ge_s;
    logic [DVS_W-1:0] step_rem_s;
    logic [DVD_W-1:0] step_dvd_s;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        trial_s = {rem_q, dvd_q[DVD_W-1]};
        ge_s    = (trial_s >= {1'b0, dvs_q});
        if (ge_s) begin
            step_rem_s = DVS_W'(trial_s - {1'b0, dvs_q});
        end else begin
            step_rem_s = trial_s[DVS_W-1:0];
        end
        step_dvd_s = {dvd_q[DVD_W-2:0], ge_s};
    end

    // Load on start, iterate while count is non-zero; soft reset cancels an in-flight divide.
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        if (srst) begin
            dvd_d = {DVD_W{1'b0}};
            dvs_d = {DVS_W{1'b0}};
            rem_d = {DVS_W{1'b0}};
            cnt_d = {CW{1'b0}};
        end else if (start) begin
            dvd_d = dividend;
            dvs_d = divisor;
            rem_d = {DVS_W{1'b0}};
            cnt_d = CNT_LOAD;
        end else if (cnt_q != {CW{1'b0}}) begin
            dvd_d = step_dvd_s;
            rem_d = step_rem_s;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= {DVD_W{1'b0}};
            dvs_q <= {DVS_W{1'b0}};
            rem_q <= {DVS_W{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy     = (cnt_q != {CW{1'b0}});
    assign q_valid  = (cnt_q == CNT_ONE);
    assign quotient = step_dvd_s;

endmodule

// File: rtl/approx_err_stats.sv
// Error-statistics engine: accumulates error count, absolute/signed error-distance
// sums, maximum error distance and relative-error sum over a sample window of
// (exact, approximate) product pairs. Relative error uses a sequential divider
// and stalls the input while it runs.
module approx_err_stats
    import approx_stats_pkg::*;
#(
    parameter int W     = PKG_W,
    parameter int CNT_W = PKG_CNT_W,
    parameter int FRAC  = PKG_FRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          num_samples,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*W-1:0]            exact,
    input  logic [2*W-1:0]            apprx,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          samples_seen,
    output logic [CNT_W-1:0]          err_count,
    output logic [2*W+CNT_W-1:0]      sum_ed_abs,
    output logic [2*W+CNT_W:0]        sum_ed_signed,
    output logic [2*W-1:0]            max_ed,
    output logic [2*W+FRAC+CNT_W-1:0] sum_re
);

    localparam int PW     = 2 * W;
    localparam int DW     = 2 * W + FRAC;
    localparam int SABS_W = PW + CNT_W;
    localparam int SSGN_W = PW + CNT_W + 1;
    localparam int SRE_W  = PW + FRAC + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    samples_seen_q, samples_seen_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [SABS_W-1:0]   sum_ed_abs_q, sum_ed_abs_d;
    logic [SSGN_W-1:0]   sum_ed_signed_q, sum_ed_signed_d;
    logic [PW-1:0]       max_ed_q, max_ed_d;
    logic [SRE_W-1:0]    sum_re_q, sum_re_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                clear_s, accept_s, div_start_s, div_commit_s, enter_done_s;
    logic [PW:0]         ed_s;
    logic [PW-1:0]       ed_abs_s;
    logic                need_div_s;
    logic [CNT_W-1:0]    seen_inc_s;
    logic                div_busy_s, div_q_valid_s;
    logic [DW-1:0]       div_quot_s;

    // Error distance of the presented pair, in PW+1 signed bits, plus its magnitude.
    always_comb begin
        ed_s = {1'b0, exact} - {1'b0, apprx};
        if (ed_s[PW]) begin
            ed_abs_s = PW'(-ed_s);
        end else begin
            ed_abs_s = ed_s[PW-1:0];
        end
        need_div_s = (exact != {PW{1'b0}}) && (ed_abs_s != {PW{1'b0}});
        seen_inc_s = samples_seen_q + CNT_ONE;
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_d      = state_q;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        div_start_s  = 1'b0;
        div_commit_s = 1'b0;
        enter_done_s = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        clear_s = 1'b1;
                        if (num_samples == {CNT_W{1'b0}}) begin
                            state_d      = ST_DONE;
                            enter_done_s = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        accept_s = 1'b1;
                        if (need_div_s) begin
                            div_start_s = 1'b1;
                            state_d     = ST_DIVIDE;
                        end else if (seen_inc_s == num_q) begin
                            state_d      = ST_DONE;
                            enter_done_s = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_DIVIDE: begin
                    // A divider that went idle without q_valid drops the sample's RE
                    // contribution instead of hanging the window.
                    if (div_q_valid_s || !div_busy_s) begin
                        div_commit_s = div_q_valid_s;
                        if (samples_seen_q == num_q) begin
                            state_d      = ST_DONE;
                            enter_done_s = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_DIVIDE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered status outputs decoded from the next state.
    always_comb begin
        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = (state_d == ST_ACCUM) || (state_d == ST_DIVIDE);
        done_d     = enter_done_s;
    end

    // Accumulator datapath: clear on start, update on accept, add quotient on divide completion.
    always_comb begin
        num_d           = num_q;
        samples_seen_d  = samples_seen_q;
        err_count_d     = err_count_q;
        sum_ed_abs_d    = sum_ed_abs_q;
        sum_ed_signed_d = sum_ed_signed_q;
        max_ed_d        = max_ed_q;
        sum_re_d        = sum_re_q;
        if (clear_s) begin
            num_d           = num_samples;
            samples_seen_d  = {CNT_W{1'b0}};
            err_count_d     = {CNT_W{1'b0}};
            sum_ed_abs_d    = {SABS_W{1'b0}};
            sum_ed_signed_d = {SSGN_W{1'b0}};
            max_ed_d        = {PW{1'b0}};
            sum_re_d        = {SRE_W{1'b0}};
        end else if (accept_s) begin
            samples_seen_d  = seen_inc_s;
            err_count_d     = err_count_q + {{(CNT_W-1){1'b0}}, (ed_abs_s != {PW{1'b0}})};
            sum_ed_abs_d    = sum_ed_abs_q + SABS_W'(ed_abs_s);
            sum_ed_signed_d = sum_ed_signed_q + {{(SSGN_W-PW-1){ed_s[PW]}}, ed_s};
            if (ed_abs_s > max_ed_q) begin
                max_ed_d = ed_abs_s;
            end else begin
                max_ed_d = max_ed_q;
            end
        end else if (div_commit_s) begin
            sum_re_d = sum_re_q + SRE_W'(div_quot_s);
        end else begin
            sum_re_d = sum_re_q;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            num_q           <= {CNT_W{1'b0}};
            samples_seen_q  <= {CNT_W{1'b0}};
            err_count_q     <= {CNT_W{1'b0}};
            sum_ed_abs_q    <= {SABS_W{1'b0}};
            sum_ed_signed_q <= {SSGN_W{1'b0}};
            max_ed_q        <= {PW{1'b0}};
            sum_re_q        <= {SRE_W{1'b0}};
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_q           <= num_d;
            samples_seen_q  <= samples_seen_d;
            err_count_q     <= err_count_d;
            sum_ed_abs_q    <= sum_ed_abs_d;
            sum_ed_signed_q <= sum_ed_signed_d;
            max_ed_q        <= max_ed_d;
            sum_re_q        <= sum_re_d;
            in_ready_q      <= in_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    seq_restoring_div #(
        .DVD_W (DW),
        .DVS_W (PW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (abort),
        .start    (div_start_s),
        .dividend ({ed_abs_s, {FRAC{1'b0}}}),
        .divisor  (exact),
        .busy     (div_busy_s),
        .q_valid  (div_q_valid_s),
        .quotient (div_quot_s)
    );

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign samples_seen  = samples_seen_q;
    assign err_count     = err_count_q;
    assign sum_ed_abs    = sum_ed_abs_q;
    assign sum_ed_signed = sum_ed_signed_q;
    assign max_ed        = max_ed_q;
    assign sum_re        = sum_re_q;

endmodule

// File: tb/tb_approx_err_stats.sv
// Directed bench for approx_err_stats: expected window results come from a
// bench-side integer model, queued at stimulus time and popped at done.
module tb_approx_err_stats;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] exact;
    logic [15:0] apprx;
    logic        busy;
    logic        done;
    logic [15:0] samples_seen;
    logic [15:0] err_count;
    logic [31:0] sum_ed_abs;
    logic [32:0] sum_ed_signed;
    logic [15:0] max_ed;
    logic [47:0] sum_re;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] seen;
        logic [15:0] errc;
        logic [31:0] sabs;
        logic [32:0] ssig;
        logic [15:0] maxe;
        logic [47:0] sre;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ex_q[$];
    logic [15:0] ap_q[$];

    approx_err_stats dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_samples   (num_samples),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .exact         (exact),
        .apprx         (apprx),
        .busy          (busy),
        .done          (done),
        .samples_seen  (samples_seen),
        .err_count     (err_count),
        .sum_ed_abs    (sum_ed_abs),
        .sum_ed_signed (sum_ed_signed),
        .max_ed        (max_ed),
        .sum_re        (sum_re)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic add(input logic [15:0] e, input logic [15:0] a);
        ex_q.push_back(e);
        ap_q.push_back(a);
    endtask

    task automatic clear_samples();
        ex_q.delete();
        ap_q.delete();
    endtask

    // Bench model of one window over the first n queued samples.
    task automatic push_expected(input int n);
        exp_t   e;
        longint ss, sa, sr;
        int     mx, ec, ed, a;
        ss = 0; sa = 0; sr = 0; mx = 0; ec = 0;
        for (int i = 0; i < n; i++) begin
            ed = int'(ex_q[i]) - int'(ap_q[i]);
            a  = (ed < 0) ? -ed : ed;
            if (a != 0) ec++;
            sa += longint'(a);
            ss += longint'(ed);
            if (a > mx) mx = a;
            if (ex_q[i] != 16'd0 && a != 0) sr += (longint'(a) * 65536) / longint'(ex_q[i]);
        end
        e.seen = 16'(n);
        e.errc = 16'(ec);
        e.sabs = 32'(sa);
        e.ssig = 33'(ss);
        e.maxe = 16'(mx);
        e.sre  = 48'(sr);
        exp_q.push_back(e);
    endtask

    task automatic push_literal(input logic [15:0] seen, input logic [15:0] errc, input logic [31:0] sabs,
                                input logic [32:0] ssig, input logic [15:0] maxe, input logic [47:0] sre);
        exp_t e;
        e.seen = seen; e.errc = errc; e.sabs = sabs; e.ssig = ssig; e.maxe = maxe; e.sre = sre;
        exp_q.push_back(e);
    endtask

    task automatic check_results(input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".samples_seen"},  64'(samples_seen),  64'(e.seen));
            chk({tag, ".err_count"},     64'(err_count),     64'(e.errc));
            chk({tag, ".sum_ed_abs"},    64'(sum_ed_abs),    64'(e.sabs));
            chk({tag, ".sum_ed_signed"}, 64'(sum_ed_signed), 64'(e.ssig));
            chk({tag, ".max_ed"},        64'(max_ed),        64'(e.maxe));
            chk({tag, ".sum_re"},        64'(sum_re),        64'(e.sre));
        end
    endtask

    // Run a complete window of n queued samples; start is poked during stalls and must be ignored.
    task automatic run_window(input string tag, input int n, output int stall_total, output int done_wait);
        int low;
        stall_total = 0;
        push_expected(n);
        start = 1'b1; num_samples = 16'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            exact = ex_q[i]; apprx = ap_q[i]; in_valid = 1'b1;
            low = 0;
            while (!in_ready && low < 100) begin
                start = 1'b1; num_samples = 16'd0;
                low++;
                step();
            end
            start = 1'b0;
            if (low > 0) chk({tag, "_held_not_taken"}, 64'(samples_seen), 64'(i));
            stall_total += low;
            step();
        end
        in_valid = 1'b0;
        done_wait = 0;
        while (!done && done_wait < 100) begin
            done_wait++;
            step();
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        check_results(tag);
        step();
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int st, dw, dseen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_samples = 16'd0;
        in_valid = 1'b0; exact = 16'd0; apprx = 16'd0;
        #12;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.busy",     64'(busy),     64'd0);
        chk("rst.done",     64'(done),     64'd0);
        push_literal(16'd0, 16'd0, 32'd0, 33'd0, 16'd0, 48'd0);
        check_results("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // All-exact window: no errors, no stalls, done right after the last accept.
        clear_samples();
        for (int i = 0; i < 4; i++) add(16'd100, 16'd100);
        run_window("exact4", 4, st, dw);
        chk("exact4.stall", 64'(st), 64'd0);
        chk("exact4.done_wait", 64'(dw), 64'd0);

        // Opposite-sign errors cancel in the signed sum.
        clear_samples();
        add(16'd100, 16'd90); add(16'd50, 16'd60);
        run_window("mixed2", 2, st, dw);
        chk("mixed2.sum_re_const", 64'(sum_re), 64'd19660);

        // exact==0: RE contributes nothing, no divide stall.
        clear_samples();
        add(16'd0, 16'd5);
        run_window("zero_exact", 1, st, dw);
        chk("zero_exact.stall", 64'(st), 64'd0);
        chk("zero_exact.done_wait", 64'(dw), 64'd0);

        // Full-scale divide: 32-cycle stall, held sample waits.
        clear_samples();
        add(16'd65025, 16'd0); add(16'd65025, 16'd65025);
        run_window("stall", 2, st, dw);
        chk("stall.cycles", 64'(st), 64'd32);
        chk("stall.sum_re_const", 64'(sum_re), 64'd65536);

        // Zero-length window.
        clear_samples();
        run_window("empty", 0, st, dw);
        chk("empty.done_wait", 64'(dw), 64'd0);

        // Large relative errors (>1.0) and extreme magnitudes, no saturation.
        clear_samples();
        add(16'd10, 16'd30); add(16'd200, 16'd199); add(16'd0, 16'd0);
        add(16'd65025, 16'd1); add(16'd1, 16'd65535);
        run_window("wide", 5, st, dw);

        // Abort during DIVIDE after 1 of 3 samples.
        push_literal(16'd1, 16'd1, 32'd10, 33'd10, 16'd10, 48'd0);
        start = 1'b1; num_samples = 16'd3;
        step();
        start = 1'b0;
        exact = 16'd100; apprx = 16'd90; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("abort.in_ready_div", 64'(in_ready), 64'd0);
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.in_ready", 64'(in_ready), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        check_results("abort");
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dseen++;
        end
        chk("abort.no_done", 64'(dseen), 64'd0);
        chk("abort.sum_re_hold", 64'(sum_re), 64'd0);

        // Asynchronous reset mid-ACCUM.
        start = 1'b1; num_samples = 16'd3;
        step();
        start = 1'b0;
        exact = 16'd0; apprx = 16'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("midrst.pre_seen", 64'(samples_seen), 64'd1);
        push_literal(16'd0, 16'd0, 32'd0, 33'd0, 16'd0, 48'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        chk("midrst.busy", 64'(busy), 64'd0);
        check_results("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Recovery after reset.
        clear_samples();
        add(16'd123, 16'd45);
        run_window("post_rst", 1, st, dw);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
